// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential shift-and-add multiplier, signed or unsigned,
// one multiplier bit per CALC cycle, sign fix-up in a final FIX cycle.
//
// Parameters:
//   WIDTH        operand width in bits (2..32)
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   start        begin a multiplication (accepted in IDLE or DONE only)
//   signed_mode  1 = two's complement operands, 0 = unsigned
//   a_in, b_in   multiplicand / multiplier, sampled with start
//   busy         high in CALC and FIX
//   done         one-cycle pulse when product is valid
//   product      2*WIDTH-bit result, held until the next FIX
// Build option:
//   MULT_EARLY_TERM_EN  leave CALC as soon as the remaining multiplier is 0
module mult_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic [PW-1:0]   prod_q;
    logic            busy_q;
    logic            done_q;

    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic             sign_d;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    mcand_d;
    logic [WIDTH-1:0] mplier_d;
    logic [CW-1:0]    cnt_d;
    logic             last_calc_d;
    logic [PW-1:0]    prod_d;
    logic             accept_d;

    always_comb begin
        // The most negative value negates to itself, which read as
        // unsigned is exactly the wanted magnitude 2^(WIDTH-1).
        a_mag_d = (signed_mode && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
        b_mag_d = (signed_mode && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
        sign_d  = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);

        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;

        last_calc_d = (cnt_d == '0);
`ifdef MULT_EARLY_TERM_EN
        // No set bits left: further iterations would only add zero.
        last_calc_d = last_calc_d | (mplier_d == '0);
`endif

        // Negating zero is a no-op, but keep it explicit.
        prod_d = (sign_q && (acc_q != '0)) ? (~acc_q + 1'b1) : acc_q;

        accept_d = start && ((state_q == IDLE) || (state_q == DONE));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept_d) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
                        mplier_q <= b_mag_d;
                        sign_q   <= sign_d;
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        state_q  <= CALC;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                    done_q <= 1'b0;
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (last_calc_d) begin
                        state_q <= FIX;
                    end
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                end
                FIX: begin
                    prod_q  <= prod_d;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule
